// File: rtl/tone_detect_pkg.sv
// Shared DSP constants for the tone detector and its sibling filter blocks:
// default parameters, FSM state encodings and the saturating magnitude helper.
package tone_detect_pkg;

  localparam int LOG2_N_DEF   = 6;
  localparam int HOLD_ON_DEF  = 3;
  localparam int HOLD_OFF_DEF = 3;
  localparam int CNT_W        = 8;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_ARMING    = 2'd1,
    ST_ON        = 2'd2,
    ST_RELEASING = 2'd3
  } tone_state_e;

  // |x| with the single unrepresentable case -32768 clamped to 32767
  function automatic logic [15:0] sat_abs(input logic [15:0] x);
    logic [15:0] r;
    if (x == 16'h8000) begin
      r = 16'h7FFF;
    end else if (x[15]) begin
      r = ~x + 16'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/tone_detect_fs_edge.sv
// Double-flop edge detector for the sample-rate strobe; rise/fall are one-clk
// pulses derived from the two synchronising flops.
module fs_edge (
  input  logic clk,
  input  logic rst,
  input  logic f_s,
  output logic rise,
  output logic fall
);

  logic pls0_q;
  logic pls1_q;

  // strobe history shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pls0_q <= 1'b0;
      pls1_q <= 1'b0;
    end else begin
      pls0_q <= f_s;
      pls1_q <= pls0_q;
    end
  end

  assign rise = pls0_q & ~pls1_q;
  assign fall = pls1_q & ~pls0_q;

endmodule

// File: rtl/tone_detect.sv
// Block-averaged magnitude level meter with hysteretic on/off tone decision.
// Samples are taken on the falling edge of f_s, after the upstream filter settles.
module tone_detect
  import tone_detect_pkg::*;
#(
  parameter int LOG2_N   = LOG2_N_DEF,
  parameter int HOLD_ON  = HOLD_ON_DEF,
  parameter int HOLD_OFF = HOLD_OFF_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_s,
  input  logic [15:0] din,
  input  logic [15:0] thr_on,
  input  logic [15:0] thr_off,
  output logic [15:0] level,
  output logic        level_vld,
  output logic        det
);

  localparam int ACC_W = 16 + LOG2_N;

  logic              fall_s;
  logic [15:0]       mag_q;
  logic              e_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  sum_s;
  logic [LOG2_N-1:0] smp_cnt_q;
  logic [15:0]       level_q;
  logic              level_vld_q;
  tone_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic              det_q;
  logic              above_on_s;
  logic              below_off_s;

  fs_edge u_fs_edge (
    .clk  (clk),
    .rst  (rst),
    .f_s  (f_s),
    .rise (),
    .fall (fall_s)
  );

  assign sum_s       = acc_q + ACC_W'(mag_q);
  assign cnt_inc_s   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign above_on_s  = (level_q >= thr_on);
  assign below_off_s = (level_q < thr_off);

  // magnitude capture, accumulation and block-end level update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_q       <= 16'd0;
      e_q         <= 1'b0;
      acc_q       <= {ACC_W{1'b0}};
      smp_cnt_q   <= {LOG2_N{1'b0}};
      level_q     <= 16'd0;
      level_vld_q <= 1'b0;
    end else begin
      level_vld_q <= 1'b0;
      e_q         <= fall_s;
      if (fall_s) begin
        mag_q <= sat_abs(din);
      end
      if (e_q) begin
        smp_cnt_q <= smp_cnt_q + {{(LOG2_N-1){1'b0}}, 1'b1};
        if (&smp_cnt_q) begin
          level_q     <= sum_s[LOG2_N +: 16];
          level_vld_q <= 1'b1;
          acc_q       <= {ACC_W{1'b0}};
        end else begin
          acc_q <= sum_s;
        end
      end
    end
  end

  // hysteresis FSM, advanced only on a fresh level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_OFF;
      cnt_q   <= {CNT_W{1'b0}};
      det_q   <= 1'b0;
    end else if (level_vld_q) begin
      case (state_q)
        ST_OFF: begin
          if (above_on_s && HOLD_ON <= 1) begin
            state_q <= ST_ON;
            cnt_q   <= {CNT_W{1'b0}};
            det_q   <= 1'b1;
          end else if (above_on_s) begin
            state_q <= ST_ARMING;
            cnt_q   <= cnt_inc_s;
            det_q   <= 1'b0;
          end else begin
            cnt_q <= {CNT_W{1'b0}};
            det_q <= 1'b0;
          end
        end
        ST_ARMING: begin
          if (above_on_s && cnt_inc_s >= CNT_W'(HOLD_ON)) begin
            state_q <= ST_ON;
            cnt_q   <= {CNT_W{1'b0}};
            det_q   <= 1'b1;
          end else if (above_on_s) begin
            cnt_q <= cnt_inc_s;
            det_q <= 1'b0;
          end else begin
            state_q <= ST_OFF;
            cnt_q   <= {CNT_W{1'b0}};
            det_q   <= 1'b0;
          end
        end
        ST_ON: begin
          if (below_off_s && HOLD_OFF <= 1) begin
            state_q <= ST_OFF;
            cnt_q   <= {CNT_W{1'b0}};
            det_q   <= 1'b0;
          end else if (below_off_s) begin
            state_q <= ST_RELEASING;
            cnt_q   <= cnt_inc_s;
            det_q   <= 1'b1;
          end else begin
            cnt_q <= {CNT_W{1'b0}};
            det_q <= 1'b1;
          end
        end
        ST_RELEASING: begin
          if (below_off_s && cnt_inc_s >= CNT_W'(HOLD_OFF)) begin
            state_q <= ST_OFF;
            cnt_q   <= {CNT_W{1'b0}};
            det_q   <= 1'b0;
          end else if (below_off_s) begin
            cnt_q <= cnt_inc_s;
            det_q <= 1'b1;
          end else begin
            state_q <= ST_ON;
            cnt_q   <= {CNT_W{1'b0}};
            det_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_OFF;
          cnt_q   <= {CNT_W{1'b0}};
          det_q   <= 1'b0;
        end
      endcase
    end else begin
      state_q <= state_q;
    end
  end

  assign level     = level_q;
  assign level_vld = level_vld_q;
  assign det       = det_q;

endmodule

// File: tb/tb_tone_detect.sv
// Directed bench for tone_detect: block levels, saturation, truncation, hysteresis,
// equality at thresholds, strobe stall and mid-block reset.
module tb_tone_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_s = 1'b0;
  logic [15:0] din = 16'd0;
  logic [15:0] thr_on = 16'hFFFF;
  logic [15:0] thr_off = 16'd0;
  logic [15:0] level;
  logic        level_vld;
  logic        det;

  int n_vec = 0;
  int n_err = 0;

  int          vld_pulses = 0;
  int          wide_cnt = 0;
  logic        vld_prev = 1'b0;
  logic        cap_next = 1'b0;
  logic [15:0] last_level = 16'd0;
  logic        det_at_vld = 1'b0;
  logic        det_after_vld = 1'b0;

  tone_detect dut (
    .clk       (clk),
    .rst       (rst),
    .f_s       (f_s),
    .din       (din),
    .thr_on    (thr_on),
    .thr_off   (thr_off),
    .level     (level),
    .level_vld (level_vld),
    .det       (det)
  );

  always #50 clk = ~clk;

  // observe level_vld pulses and det around them
  always @(negedge clk) begin
    if (cap_next) begin
      det_after_vld <= det;
      cap_next      <= 1'b0;
    end
    if (level_vld) begin
      vld_pulses <= vld_pulses + 1;
      last_level <= level;
      det_at_vld <= det;
      cap_next   <= 1'b1;
      if (vld_prev) wide_cnt <= wide_cnt + 1;
    end
    vld_prev <= level_vld;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_sample(input logic [15:0] v);
    din = v;
    f_s = 1'b1;
    repeat (4) @(negedge clk);
    f_s = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // one full block alternating a/b; optional strobe stall before sample stall_at
  task automatic run_block(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input int exp_level, input int exp_det_at, input int exp_det_after,
                           input int stall_at);
    int p0;
    p0 = vld_pulses;
    for (int i = 0; i < 64; i++) begin
      if (i == stall_at) begin
        repeat (300) @(negedge clk);
        #1;
        chk({tag, "_stall_novld"}, vld_pulses - p0, 0);
      end
      send_sample((i % 2 == 1) ? b : a);
    end
    #1;
    chk({tag, "_pulses"}, vld_pulses - p0, 1);
    chk({tag, "_level"}, int'(last_level), exp_level);
    chk({tag, "_det_at_vld"}, int'(det_at_vld), exp_det_at);
    chk({tag, "_det_after"}, int'(det_after_vld), exp_det_after);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_vld", int'(level_vld), 0);
    chk("rst_det", int'(det), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // level metering with the FSM held off
    thr_on  = 16'hFFFF;
    thr_off = 16'd0;
    run_block("p1000", 16'd1000, 16'd1000, 1000, 0, 0, -1);
    run_block("p1000_stall", 16'd1000, 16'd1000, 1000, 0, 0, 32);
    run_block("neg_sat", 16'h8000, 16'h8000, 32767, 0, 0, -1);
    run_block("trunc", 16'd7, 16'hFFF8, 7, 0, 0, -1);

    // basic on/off hysteresis
    thr_on  = 16'd800;
    thr_off = 16'd400;
    run_block("on1", 16'd1000, 16'hFC18, 1000, 0, 0, -1);
    run_block("on2", 16'd1000, 16'hFC18, 1000, 0, 0, -1);
    run_block("on3", 16'd1000, 16'hFC18, 1000, 0, 1, -1);
    run_block("off1", 16'd0, 16'd0, 0, 1, 1, -1);
    run_block("off2", 16'd0, 16'd0, 0, 1, 1, -1);
    run_block("off3", 16'd0, 16'd0, 0, 1, 0, -1);

    // arming count restarts after a low block
    run_block("arm1", 16'd900, 16'd900, 900, 0, 0, -1);
    run_block("arm2", 16'd900, 16'd900, 900, 0, 0, -1);
    run_block("arm_lo", 16'd700, 16'd700, 700, 0, 0, -1);
    run_block("arm4", 16'd900, 16'd900, 900, 0, 0, -1);
    run_block("arm5", 16'd900, 16'd900, 900, 0, 0, -1);
    run_block("arm6", 16'd900, 16'd900, 900, 0, 1, -1);
    run_block("drop1", 16'd0, 16'd0, 0, 1, 1, -1);
    run_block("drop2", 16'd0, 16'd0, 0, 1, 1, -1);
    run_block("drop3", 16'd0, 16'd0, 0, 1, 0, -1);

    // equality at both thresholds
    run_block("eq_on1", 16'd800, 16'd800, 800, 0, 0, -1);
    run_block("eq_on2", 16'd800, 16'd800, 800, 0, 0, -1);
    run_block("eq_on3", 16'd800, 16'd800, 800, 0, 1, -1);
    for (int k = 0; k < 5; k++) begin
      run_block($sformatf("eq_off%0d", k), 16'd400, 16'd400, 400, 1, 1, -1);
    end

    // reset mid-block with the tone present
    for (int i = 0; i < 30; i++) send_sample(16'd500);
    rst = 1'b0;
    #1;
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_vld", int'(level_vld), 0);
    chk("mid_rst_det", int'(det), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_block("post_rst", 16'd200, 16'd200, 200, 0, 0, -1);

    chk("vld_width", wide_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tone_detect.md
TONE_DETECT -- requirements
Module: tone_detect

Interface
REQ-001 SHALL have parameter LOG2_N, default 6; samples per averaging block = 2^LOG2_N, legal range 2..10.
REQ-002 SHALL have parameter HOLD_ON, default 3; consecutive above-threshold blocks required to declare a tone.
REQ-003 SHALL have parameter HOLD_OFF, default 3; consecutive below-threshold blocks required to drop a tone.
REQ-004 clk  input  1  system clock, 10 MHz.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 f_s  input  1  sample-rate strobe (40 kHz level signal), same source as the upstream band-pass filter.
REQ-007 din  input  16  signed filtered sample from the upstream band-pass filter output.
REQ-008 thr_on  input  16  unsigned level threshold for tone-on; quasi-static.
REQ-009 thr_off  input  16  unsigned level threshold for tone-off; quasi-static.
REQ-010 level  output  16  unsigned mean absolute value of the last completed block.
REQ-011 level_vld  output  1  one-clk pulse when level updates.
REQ-012 det  output  1  tone-present flag.

Function
REQ-013 SHALL register f_s through two flops (pls0, pls1); sample event E = pls1 & ~pls0 (falling edge), so din is sampled after the upstream output has settled.
REQ-014 On E, SHALL register mag = |din|, saturating -32768 to 32767.
REQ-015 Cycle after E, SHALL add mag into an unsigned (16+LOG2_N)-bit accumulator and increment a LOG2_N-bit sample counter; no overflow is possible.
REQ-016 When the counter wraps from 2^LOG2_N-1 to 0, SHALL load level = (acc+mag) >> LOG2_N (truncating), pulse level_vld for exactly one clk, and clear acc to 0 at the same edge.
REQ-017 Latency: level/level_vld SHALL be visible 2 clks after the E cycle of the last sample of the block.
REQ-018 FSM states: OFF, ARMING, ON, RELEASING; updates only in cycles with level_vld=1.
REQ-019 OFF: level >= thr_on -> ARMING with cnt=1, or -> ON directly if HOLD_ON=1; otherwise stay.
REQ-020 ARMING: level >= thr_on -> cnt+1; on reaching HOLD_ON -> ON; level < thr_on -> OFF, cnt=0.
REQ-021 ON: level < thr_off -> RELEASING with cnt=1, or -> OFF directly if HOLD_OFF=1; otherwise stay.
REQ-022 RELEASING: level < thr_off -> cnt+1; on reaching HOLD_OFF -> OFF; level >= thr_off -> ON, cnt=0.
REQ-023 det SHALL be 1 in ON and RELEASING, 0 in OFF and ARMING, registered, changing 1 clk after the deciding level_vld.
REQ-024 Equality: level == thr_on counts as above; level == thr_off counts as not below.
REQ-025 f_s stopped: no accumulation, no level_vld, FSM frozen; partial block resumes when f_s restarts.
REQ-026 thr_on < thr_off is not rejected; comparisons are applied as written.

Reset
REQ-027 Asserting rst SHALL immediately clear pls0, pls1, mag, acc, counter, level, level_vld, cnt and det, and force FSM to OFF, including mid-block.
REQ-028 After rst deassertion, the first block SHALL start with the first subsequent E.

Structure
REQ-029 FSM state encodings and default parameter values SHALL reside in a shared DSP constants package.
REQ-030 The f_s double-flop edge detector SHALL be a sub-module fs_edge with outputs rise and fall, reusable by sibling filter blocks.

Verification
REQ-031 din=+1000 constant, LOG2_N=6 -> level=1000 with level_vld every 64 E events; exactly one clk wide.
REQ-032 din=-32768 constant -> level=32767 (saturation); din alternating +7/-8 -> level=7 (truncation).
REQ-033 thr_on=800, thr_off=400, din=+/-1000 -> det rises 1 clk after the 3rd level_vld; then din=0 -> det falls 1 clk after the 3rd zero-level block.
REQ-034 Levels 900, 900, 700, 900, 900, 900 with thr_on=800 -> det stays 0 until after the 6th block (ARMING count reset).
REQ-035 rst pulsed after 30 samples of a block, with det=1 -> all outputs 0 immediately; next level_vld after 64 new E events, with level reflecting only post-reset samples.
REQ-036 level == thr_on exactly for 3 blocks -> det=1; then level == thr_off for 5 blocks -> det remains 1.
